// File: rtl/furv_mem_sequencer_if.sv
// Shared bus bundle between the furv core, the memory sequencer and one
// Wishbone-style memory port.
//   master : sequencer view (drives instruction, core data response, memory request)
//   slave  : environment view (core PC/data request and memory response)
interface furv_mem_sequencer_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 30;
  localparam int unsigned SEL_W  = 4;

  // core side
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] instruction;
  logic              d_mem;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [SEL_W-1:0]  d_sel;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  // memory side
  logic              m_cyc;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [SEL_W-1:0]  m_sel;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ack;

  modport master (
    input  pc, d_mem, d_we, d_addr, d_sel, d_wdata, m_rdata, m_ack,
    output instruction, d_rdata, d_ack, m_cyc, m_we, m_addr, m_sel, m_wdata
  );

  modport slave (
    output pc, d_mem, d_we, d_addr, d_sel, d_wdata, m_rdata, m_ack,
    input  instruction, d_rdata, d_ack, m_cyc, m_we, m_addr, m_sel, m_wdata
  );
endinterface

// File: rtl/furv_mem_sequencer.sv
// Single-port memory sequencer for the furv core. Alternates instruction
// fetch and data access on one memory port, holds the fetched instruction
// for the core and feeds a stalling bubble while none is valid. Includes a
// bus watchdog with sticky first-error capture and a retired counter.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : core + memory bundle (master modport)
//   err_clr     : clears bus_err (a simultaneous watchdog fire wins)
//   bus_err     : sticky watchdog flag
//   err_addr    : word address of the first timed-out cycle
//   retired     : retired-instruction count, wraps
module furv_mem_sequencer #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [31:0] BUBBLE  = 32'h00002003
) (
  input  logic                         clk,
  input  logic                         rst_n,
  furv_mem_sequencer_if.master         bus,
  input  logic                         err_clr,
  output logic                         bus_err,
  output logic [29:0]                  err_addr,
  output logic [31:0]                  retired
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 30;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned WAIT_W = 16;
  localparam logic [DATA_W-1:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_DATA  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                retire;
  logic                fire;
  logic                timeout_hit;

  logic [DATA_W-1:0]   instruction_c;
  logic [DATA_W-1:0]   d_rdata_c;
  logic                d_ack_c;
  logic                m_cyc_c;
  logic                m_we_c;
  logic [ADDR_W-1:0]   m_addr_c;
  logic [SEL_W-1:0]    m_sel_c;
  logic [DATA_W-1:0]   m_wdata_c;

  // PC byte offset is meaningless for word fetches
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^bus.pc[1:0];

  // Watchdog compares against the already-accumulated wait count
  assign timeout_hit = (wait_q == WAIT_W'(TIMEOUT)) && !bus.m_ack;

  // Next-state, bus steering and commit decisions
  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    retire        = 1'b0;
    fire          = 1'b0;
    instruction_c = BUBBLE;
    d_rdata_c     = bus.m_rdata;
    d_ack_c       = 1'b0;
    m_cyc_c       = 1'b0;
    m_we_c        = 1'b0;
    m_addr_c      = bus.pc[DATA_W-1:2];
    m_sel_c       = {SEL_W{1'b1}};
    m_wdata_c     = '0;

    case (state_q)
      S_RESET: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        m_cyc_c = 1'b1;
        if (bus.m_ack) begin
          ir_d    = bus.m_rdata;
          state_d = S_EXEC;
        end else if (timeout_hit) begin
          // Hand the core a NOP so it steps past the dead fetch
          fire    = 1'b1;
          ir_d    = NOP;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        instruction_c = ir_q;
        if (bus.d_mem) begin
          state_d = S_DATA;
        end else begin
          retire  = 1'b1;
          ir_d    = BUBBLE;
          state_d = S_FETCH;
        end
      end

      S_DATA: begin
        instruction_c = ir_q;
        m_cyc_c       = 1'b1;
        m_we_c        = bus.d_we;
        m_addr_c      = bus.d_addr;
        m_sel_c       = bus.d_sel;
        m_wdata_c     = bus.d_wdata;
        d_ack_c       = bus.m_ack;
        if (bus.m_ack) begin
          retire  = 1'b1;
          ir_d    = BUBBLE;
          state_d = S_FETCH;
        end else if (timeout_hit) begin
          // Complete the access with zero data so the core can move on
          fire      = 1'b1;
          d_ack_c   = 1'b1;
          d_rdata_c = '0;
          retire    = 1'b1;
          ir_d      = BUBBLE;
          state_d   = S_FETCH;
        end
      end

      default: begin
        state_d = S_RESET;
      end
    endcase

    // Wait count tracks consecutive unacked cycles of the current access
    if ((state_d != state_q) || bus.m_ack || !m_cyc_c) begin
      wait_d = '0;
    end else begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RESET;
      ir_q     <= BUBBLE;
      wait_q   <= '0;
      bus_err  <= 1'b0;
      err_addr <= '0;
      retired  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
      if (retire) begin
        retired <= retired + DATA_W'(1);
      end
      // A fire in the same cycle as err_clr keeps the flag set
      if (fire) begin
        bus_err <= 1'b1;
        if (!bus_err) begin
          err_addr <= m_addr_c;
        end
      end else if (err_clr) begin
        bus_err <= 1'b0;
      end
    end
  end

  assign bus.instruction = instruction_c;
  assign bus.d_rdata     = d_rdata_c;
  assign bus.d_ack       = d_ack_c;
  assign bus.m_cyc       = m_cyc_c;
  assign bus.m_we        = m_we_c;
  assign bus.m_addr      = m_addr_c;
  assign bus.m_sel       = m_sel_c;
  assign bus.m_wdata     = m_wdata_c;

endmodule

// File: tb/tb_furv_mem_sequencer.sv
// Directed bench for furv_mem_sequencer: reset, zero-wait fetch/exec,
// waited load, byte store, fetch and data watchdog, err_clr, mid-access reset.
module tb_furv_mem_sequencer;

  localparam logic [31:0] BUB = 32'h00002003;

  logic        clk;
  logic        rst_n;
  logic        err_clr;
  logic        bus_err;
  logic [29:0] err_addr;
  logic [31:0] retired;

  int n_cmp = 0;
  int n_err = 0;

  furv_mem_sequencer_if bus ();

  furv_mem_sequencer #(
    .TIMEOUT (4),
    .BUBBLE  (BUB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.master),
    .err_clr  (err_clr),
    .bus_err  (bus_err),
    .err_addr (err_addr),
    .retired  (retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then apply stimulus there
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    err_clr     = 1'b0;
    bus.pc      = 32'h0;
    bus.d_mem   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 30'h0;
    bus.d_sel   = 4'h0;
    bus.d_wdata = 32'h0;
    bus.m_rdata = 32'h0;
    bus.m_ack   = 1'b0;

    // ---- reset state ----
    next_cycle();
    next_cycle();
    #1;
    chk("rst_m_cyc", 32'(bus.m_cyc), 32'd0);
    chk("rst_d_ack", 32'(bus.d_ack), 32'd0);
    chk("rst_m_we", 32'(bus.m_we), 32'd0);
    chk("rst_instr", bus.instruction, BUB);
    chk("rst_retired", retired, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_err_addr", 32'(err_addr), 32'd0);
    rst_n = 1'b1;

    // ---- cycle 1: FETCH word 0, zero-wait ----
    next_cycle();
    bus.m_ack = 1'b1; bus.m_rdata = 32'h00500093;
    #1;
    chk("c1_m_cyc", 32'(bus.m_cyc), 32'd1);
    chk("c1_m_addr", 32'(bus.m_addr), 32'd0);
    chk("c1_m_we", 32'(bus.m_we), 32'd0);
    chk("c1_m_sel", 32'(bus.m_sel), 32'hF);
    chk("c1_instr", bus.instruction, BUB);

    // ---- cycle 2: EXEC addi ----
    next_cycle();
    bus.m_ack = 1'b0; bus.d_mem = 1'b0;
    #1;
    chk("c2_instr", bus.instruction, 32'h00500093);
    chk("c2_m_cyc", 32'(bus.m_cyc), 32'd0);

    // ---- cycle 3: FETCH word 1, returns a load ----
    next_cycle();
    bus.pc = 32'd4;
    bus.m_ack = 1'b1; bus.m_rdata = 32'h0000A103;
    #1;
    chk("c3_retired", retired, 32'd1);
    chk("c3_m_cyc", 32'(bus.m_cyc), 32'd1);
    chk("c3_m_addr", 32'(bus.m_addr), 32'd1);
    chk("c3_instr", bus.instruction, BUB);

    // ---- cycle 4: EXEC load ----
    next_cycle();
    bus.m_ack = 1'b0; bus.m_rdata = 32'hDEADBEEF;
    bus.d_mem = 1'b1; bus.d_we = 1'b0; bus.d_addr = 30'h100; bus.d_sel = 4'hF;
    #1;
    chk("c4_instr", bus.instruction, 32'h0000A103);
    chk("c4_m_cyc", 32'(bus.m_cyc), 32'd0);
    chk("c4_d_ack", 32'(bus.d_ack), 32'd0);

    // ---- cycles 5..7: DATA with two wait states ----
    next_cycle();
    #1;
    chk("c5_m_cyc", 32'(bus.m_cyc), 32'd1);
    chk("c5_m_addr", 32'(bus.m_addr), 32'h100);
    chk("c5_d_ack", 32'(bus.d_ack), 32'd0);
    next_cycle();
    #1;
    chk("c6_m_cyc", 32'(bus.m_cyc), 32'd1);
    chk("c6_d_ack", 32'(bus.d_ack), 32'd0);
    next_cycle();
    bus.m_ack = 1'b1;
    #1;
    chk("c7_m_cyc", 32'(bus.m_cyc), 32'd1);
    chk("c7_d_ack", 32'(bus.d_ack), 32'd1);
    chk("c7_d_rdata", bus.d_rdata, 32'hDEADBEEF);
    chk("c7_instr", bus.instruction, 32'h0000A103);

    // ---- cycle 8: FETCH word 2 returns sb; core data port ignored here ----
    next_cycle();
    bus.pc = 32'd8;
    bus.m_ack = 1'b1; bus.m_rdata = 32'h00208123;
    bus.d_mem = 1'b1; bus.d_we = 1'b1; bus.d_addr = 30'h040;
    bus.d_sel = 4'b0100; bus.d_wdata = 32'h00AB0000;
    #1;
    chk("c8_retired", retired, 32'd2);
    chk("c8_m_addr", 32'(bus.m_addr), 32'd2);
    chk("c8_m_we", 32'(bus.m_we), 32'd0);
    chk("c8_d_ack", 32'(bus.d_ack), 32'd0);

    // ---- cycle 9: EXEC store ----
    next_cycle();
    bus.m_ack = 1'b1;
    #1;
    chk("c9_m_cyc", 32'(bus.m_cyc), 32'd0);
    chk("c9_d_ack", 32'(bus.d_ack), 32'd0);

    // ---- cycle 10: DATA store, zero-wait ----
    next_cycle();
    bus.m_ack = 1'b1;
    #1;
    chk("c10_m_we", 32'(bus.m_we), 32'd1);
    chk("c10_m_sel", 32'(bus.m_sel), 32'b0100);
    chk("c10_m_wdata", bus.m_wdata, 32'h00AB0000);
    chk("c10_m_addr", 32'(bus.m_addr), 32'h040);
    chk("c10_d_ack", 32'(bus.d_ack), 32'd1);

    // ---- cycles 11..15: FETCH word 3 never acked, fire in cycle 15 ----
    next_cycle();
    bus.pc = 32'd12;
    bus.m_ack = 1'b0; bus.d_mem = 1'b0; bus.d_we = 1'b0;
    #1;
    chk("c11_retired", retired, 32'd3);
    chk("c11_m_addr", 32'(bus.m_addr), 32'd3);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      #1;
      chk("fetch_wait_m_cyc", 32'(bus.m_cyc), 32'd1);
    end
    chk("c15_bus_err", 32'(bus_err), 32'd0);

    // ---- cycle 16: EXEC of injected NOP ----
    next_cycle();
    #1;
    chk("c16_instr", bus.instruction, 32'h00000013);
    chk("c16_bus_err", 32'(bus_err), 32'd1);
    chk("c16_err_addr", 32'(err_addr), 32'd3);
    chk("c16_m_cyc", 32'(bus.m_cyc), 32'd0);

    // ---- cycle 17: FETCH word 4 returns a load ----
    next_cycle();
    bus.pc = 32'd16;
    bus.m_ack = 1'b1; bus.m_rdata = 32'h0000A103;
    #1;
    chk("c17_retired", retired, 32'd4);
    chk("c17_m_addr", 32'(bus.m_addr), 32'd4);

    // ---- cycle 18: EXEC load to a dead address ----
    next_cycle();
    bus.m_ack = 1'b0; bus.m_rdata = 32'h12345678;
    bus.d_mem = 1'b1; bus.d_we = 1'b0; bus.d_addr = 30'h200; bus.d_sel = 4'hF;
    #1;
    chk("c18_d_ack", 32'(bus.d_ack), 32'd0);

    // ---- cycles 19..23: DATA never acked, fire in cycle 23 ----
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      #1;
      chk("data_wait_d_ack", 32'(bus.d_ack), 32'd0);
    end
    next_cycle();
    #1;
    chk("c23_d_ack", 32'(bus.d_ack), 32'd1);
    chk("c23_d_rdata", bus.d_rdata, 32'd0);
    chk("c23_m_addr", 32'(bus.m_addr), 32'h200);

    // ---- cycle 24: FETCH word 5, clear error with no fire ----
    next_cycle();
    bus.pc = 32'd20; bus.d_mem = 1'b0;
    err_clr = 1'b1;
    #1;
    chk("c24_retired", retired, 32'd5);
    chk("c24_bus_err", 32'(bus_err), 32'd1);
    chk("c24_err_addr", 32'(err_addr), 32'd3);
    chk("c24_d_rdata", bus.d_rdata, 32'h12345678);

    // ---- cycle 25: FETCH acked with a store ----
    next_cycle();
    err_clr = 1'b0;
    bus.m_ack = 1'b1; bus.m_rdata = 32'h00208123;
    #1;
    chk("c25_bus_err", 32'(bus_err), 32'd0);
    chk("c25_err_addr", 32'(err_addr), 32'd3);

    // ---- cycle 26: EXEC store ----
    next_cycle();
    bus.m_ack = 1'b0;
    bus.d_mem = 1'b1; bus.d_we = 1'b1; bus.d_addr = 30'h080;
    bus.d_sel = 4'b0001; bus.d_wdata = 32'h000000CD;

    // ---- cycle 27: DATA pending, reset mid-cycle ----
    next_cycle();
    #1;
    chk("c27_m_cyc", 32'(bus.m_cyc), 32'd1);
    chk("c27_m_we", 32'(bus.m_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2_m_cyc", 32'(bus.m_cyc), 32'd0);
    chk("rst2_m_we", 32'(bus.m_we), 32'd0);
    chk("rst2_d_ack", 32'(bus.d_ack), 32'd0);
    chk("rst2_retired", retired, 32'd0);
    chk("rst2_instr", bus.instruction, BUB);

    next_cycle();
    bus.pc = 32'd0; bus.d_mem = 1'b0; bus.d_we = 1'b0;
    rst_n = 1'b1;

    // ---- first access after release is a fetch ----
    next_cycle();
    #1;
    chk("post_m_cyc", 32'(bus.m_cyc), 32'd1);
    chk("post_m_we", 32'(bus.m_we), 32'd0);
    chk("post_m_addr", 32'(bus.m_addr), 32'd0);
    chk("post_instr", bus.instruction, BUB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
